// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one byte-addressed data memory between port A (CPU MEM stage) and
// port B (debug/loader) using round-robin arbitration. Each access has three
// phases:
//   - arbitration in IDLE or RESP;
//   - one ACCESS cycle that drives the memory strobes;
//   - one RESP cycle that acknowledges the requester.
// All outputs come straight from flops. Their next values are decoded from
// the next FSM state.
//
// Optional feature, enabled by defining the macro DMEM_ARB_RANGE_CHK_EN:
// misaligned or out-of-range accesses still take their slot, but they never
// strobe memory and are acknowledged with err_o = 1.

module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // port A (CPU MEM stage)
  input  logic        a_req_i,
  input  logic        a_we_i,
  input  logic [31:0] a_addr_i,
  input  logic [31:0] a_wdata_i,
  output logic        a_gnt_o,
  output logic        a_ack_o,
  output logic [31:0] a_rdata_o,
  // port B (debug/loader)
  input  logic        b_req_i,
  input  logic        b_we_i,
  input  logic [31:0] b_addr_i,
  input  logic [31:0] b_wdata_i,
  output logic        b_gnt_o,
  output logic        b_ack_o,
  output logic [31:0] b_rdata_o,
  // shared status
  output logic        err_o,
  // data memory side
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_write_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_rdata_i
);

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam logic RANGE_CHK_EN = 1'b1;
`else
  localparam logic RANGE_CHK_EN = 1'b0;
`endif

  localparam logic        PORT_A         = 1'b0;
  localparam logic        PORT_B         = 1'b1;
  localparam logic [31:0] LAST_WORD_ADDR = 32'(MEM_BYTES - 32'd4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Sequencer state and latched access
  state_e      state_q, state_d;
  logic        rr_q, rr_d;        // port that wins a tie
  logic        id_q, id_d;        // port owning the current access
  logic        we_q, we_d;
  logic        flag_q, flag_d;    // access blocked by the range check
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // Registered outputs
  logic        a_gnt_q, a_gnt_d;
  logic        b_gnt_q, b_gnt_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;

  // Arbitration helpers
  logic        a_elig_s;
  logic        b_elig_s;
  logic        grant_s;
  logic        winner_s;

  // Flags a misaligned address, or one whose word would run past the end of
  // memory. The flag is always 0 when the check is compiled out.
  function automatic logic range_violation(input logic [31:0] addr);
    logic bad;
    bad = (addr[1:0] != 2'b00) || (addr > LAST_WORD_ADDR);
    return RANGE_CHK_EN & bad;
  endfunction

  // Find the ports that may compete now, and the round-robin winner.
  // The port being acked is masked because its req is still high this cycle.
  always_comb begin
    a_elig_s = a_req_i;
    b_elig_s = b_req_i;
    if (state_q == ST_RESP) begin
      if (id_q == PORT_A) begin
        a_elig_s = 1'b0;
      end else begin
        b_elig_s = 1'b0;
      end
    end else begin
      a_elig_s = a_req_i;
      b_elig_s = b_req_i;
    end

    grant_s = ((state_q == ST_IDLE) || (state_q == ST_RESP)) && (a_elig_s || b_elig_s);

    if (a_elig_s && b_elig_s) begin
      winner_s = rr_q;
    end else if (b_elig_s) begin
      winner_s = PORT_B;
    end else begin
      winner_s = PORT_A;
    end
  end

  // Next FSM state, the access latch and read-data capture
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    we_d    = we_q;
    flag_d  = flag_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (grant_s) begin
          state_d = ST_ACCESS;
          rr_d    = ~winner_s;
          id_d    = winner_s;
          if (winner_s == PORT_B) begin
            we_d    = b_we_i;
            addr_d  = b_addr_i;
            wdata_d = b_wdata_i;
          end else begin
            we_d    = a_we_i;
            addr_d  = a_addr_i;
            wdata_d = a_wdata_i;
          end
          flag_d = range_violation(addr_d);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        // Only an unblocked read may update the shared read register.
        if (!we_q && !flag_q) begin
          rdata_d = mem_rdata_i;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode the next output values from the next state.
  // This lets every output come from a flop with no extra cycle of latency.
  always_comb begin
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;

    case (state_d)
      ST_ACCESS: begin
        mem_addr_d  = addr_d;
        mem_wdata_d = wdata_d;
        mem_write_d = we_d & ~flag_d;
        mem_read_d  = ~we_d & ~flag_d;
        a_gnt_d     = (id_d == PORT_A);
        b_gnt_d     = (id_d == PORT_B);
      end
      ST_RESP: begin
        a_ack_d = (id_d == PORT_A);
        b_ack_d = (id_d == PORT_B);
        err_d   = flag_d;
      end
      default: begin
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
      end
    endcase
  end

  // Sequencer state, round-robin pointer, access latch and read register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      rr_q    <= PORT_A;
      id_q    <= PORT_A;
      we_q    <= 1'b0;
      flag_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      flag_q  <= flag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Output registers; reset clears them immediately
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  assign a_gnt_o     = a_gnt_q;
  assign b_gnt_o     = b_gnt_q;
  assign a_ack_o     = a_ack_q;
  assign b_ack_o     = b_ack_q;
  assign err_o       = err_q;
  assign a_rdata_o   = rdata_q;
  assign b_rdata_o   = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_write_o = mem_write_q;
  assign mem_read_o  = mem_read_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Random and directed stimulus for dmem_arbiter. The bench compares the DUT
// with a slot-level reference model. In that model an access is "in flight"
// for one cycle and then "being acknowledged" for one cycle. A new winner may
// be chosen only when nothing is in flight. The bench also emulates the data
// memory.

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif
  localparam int MEM_BYTES = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        rst_n_i;
  logic        a_req_i, a_we_i, b_req_i, b_we_i;
  logic [31:0] a_addr_i, a_wdata_i, b_addr_i, b_wdata_i;
  logic        a_gnt_o, a_ack_o, b_gnt_o, b_ack_o, err_o;
  logic [31:0] a_rdata_o, b_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_write_o, mem_read_o;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
    .a_gnt_o(a_gnt_o), .a_ack_o(a_ack_o), .a_rdata_o(a_rdata_o),
    .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
    .b_gnt_o(b_gnt_o), .b_ack_o(b_ack_o), .b_rdata_o(b_rdata_o),
    .err_o(err_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // requester state, index 0 = port A, 1 = port B
  txn_t q_a[$];
  txn_t q_b[$];
  txn_t cur [2];
  bit   act [2];
  bit   done_pend [2];
  int   wait_c [2];
  int   issued [2];
  int   acked [2];
  int   gap_pct;

  // reference model
  bit          m_acc_v, m_acc_p, m_acc_f;
  txn_t        m_acc;
  bit          m_ack_v, m_ack_p, m_ack_f;
  bit          m_rr;
  logic [31:0] m_rdata;
  logic [31:0] smem [8];

  // environment memory and observation counters
  logic [31:0] env_mem [8];
  int          cyc, wr_pulses, rd_pulses, err_pulses, overlap_cnt;
  int          ack_log[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    return RANGE_EN && ((a % 32'd4) != 32'd0 || a + 32'd4 > 32'(MEM_BYTES));
  endfunction

  function automatic bit all_idle();
    return q_a.size() == 0 && q_b.size() == 0 && !act[0] && !act[1] && !m_acc_v && !m_ack_v;
  endfunction

  task automatic push_txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    if (p == 0) q_a.push_back(t); else q_b.push_back(t);
  endtask

  task automatic model_reset();
    m_acc_v = 1'b0; m_acc_p = 1'b0; m_acc_f = 1'b0; m_acc = '0;
    m_ack_v = 1'b0; m_ack_p = 1'b0; m_ack_f = 1'b0;
    m_rr = 1'b0; m_rdata = 32'd0;
  endtask

  // Advance the model across one active edge, using the request inputs held over it.
  task automatic model_step();
    bit old_acc_v, old_ack_v, old_ack_p, ea, eb, w;
    old_acc_v = m_acc_v; old_ack_v = m_ack_v; old_ack_p = m_ack_p;
    m_ack_v = m_acc_v; m_ack_p = m_acc_p; m_ack_f = m_acc_f;
    if (old_acc_v && !m_acc.we && !m_acc_f) m_rdata = smem[m_acc.addr[4:2]];
    m_acc_v = 1'b0;
    if (!old_acc_v) begin
      ea = a_req_i && !(old_ack_v && old_ack_p == 1'b0);
      eb = b_req_i && !(old_ack_v && old_ack_p == 1'b1);
      if (ea || eb) begin
        w = (ea && eb) ? m_rr : eb;
        m_rr = !w;
        m_acc_v = 1'b1;
        m_acc_p = w;
        if (w) begin m_acc.we = b_we_i; m_acc.addr = b_addr_i; m_acc.wdata = b_wdata_i; end
        else   begin m_acc.we = a_we_i; m_acc.addr = a_addr_i; m_acc.wdata = a_wdata_i; end
        m_acc_f = bad_addr(m_acc.addr);
        if (m_acc.we && !m_acc_f) smem[m_acc.addr[4:2]] = m_acc.wdata;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("a_gnt", 32'(a_gnt_o), 32'(m_acc_v && !m_acc_p));
    check_val("b_gnt", 32'(b_gnt_o), 32'(m_acc_v && m_acc_p));
    check_val("mem_write", 32'(mem_write_o), 32'(m_acc_v && m_acc.we && !m_acc_f));
    check_val("mem_read", 32'(mem_read_o), 32'(m_acc_v && !m_acc.we && !m_acc_f));
    check_val("mem_addr", mem_addr_o, m_acc_v ? m_acc.addr : 32'd0);
    check_val("mem_wdata", mem_wdata_o, m_acc_v ? m_acc.wdata : 32'd0);
    check_val("a_ack", 32'(a_ack_o), 32'(m_ack_v && !m_ack_p));
    check_val("b_ack", 32'(b_ack_o), 32'(m_ack_v && m_ack_p));
    check_val("err", 32'(err_o), 32'(m_ack_v && m_ack_f));
    check_val("a_rdata", a_rdata_o, m_rdata);
    check_val("b_rdata", b_rdata_o, m_rdata);
  endtask

  // Emulate the memory: apply writes and present read data for the capture edge.
  task automatic env_update();
    if (mem_write_o) begin env_mem[mem_addr_o[4:2]] = mem_wdata_o; wr_pulses++; end
    if (mem_read_o) begin mem_rdata_i = env_mem[mem_addr_o[4:2]]; rd_pulses++; end
    else mem_rdata_i = $urandom();
    if (err_o) err_pulses++;
    if (a_gnt_o && b_gnt_o) overlap_cnt++;
    if (a_ack_o || b_ack_o) ack_log.push_back(cyc);
  endtask

  task automatic drive_ports();
    a_req_i = act[0]; a_we_i = cur[0].we; a_addr_i = cur[0].addr; a_wdata_i = cur[0].wdata;
    b_req_i = act[1]; b_we_i = cur[1].we; b_addr_i = cur[1].addr; b_wdata_i = cur[1].wdata;
  endtask

  // Requesters hold a request through its ack cycle and release it on the next cycle.
  task automatic update_ports();
    bit ack_now;
    for (int p = 0; p < 2; p++) begin
      ack_now = (p == 0) ? a_ack_o : b_ack_o;
      if (done_pend[p]) begin
        act[p] = 1'b0; done_pend[p] = 1'b0;
      end else if (act[p] && ack_now) begin
        done_pend[p] = 1'b1; acked[p]++;
      end
      if (act[p] && !done_pend[p]) begin
        wait_c[p]++;
        if (wait_c[p] > 12) begin
          check_val("ack_wait_bound", 32'(wait_c[p]), 32'd12);
          act[p] = 1'b0;
        end
      end
      if (!act[p] && int'($urandom_range(99)) >= gap_pct) begin
        if (p == 0 && q_a.size() > 0) begin
          cur[0] = q_a.pop_front(); act[0] = 1'b1; wait_c[0] = 0; issued[0]++;
        end else if (p == 1 && q_b.size() > 0) begin
          cur[1] = q_b.pop_front(); act[1] = 1'b1; wait_c[1] = 0; issued[1]++;
        end
      end
    end
    drive_ports();
  endtask

  task automatic clear_ports();
    q_a.delete(); q_b.delete();
    for (int p = 0; p < 2; p++) begin
      if (act[p] && !done_pend[p]) issued[p]--;
      act[p] = 1'b0; done_pend[p] = 1'b0; wait_c[p] = 0; cur[p] = '0;
    end
    drive_ports();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      model_step();
      check_outputs();
      env_update();
      update_ports();
    end
  endtask

  task automatic run_until_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (all_idle()) break;
      run_cycles(1);
    end
    if (!all_idle()) check_val("drain_bound", 32'd1, 32'd0);
  endtask

  // Hold reset for a few cycles, checking that the outputs stay cleared; called at a negedge.
  task automatic reset_hold();
    rst_n_i = 1'b0;
    clear_ports();
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n_i = 1'b1;
  endtask

  initial begin
    int rd0, err0, wr0;
    rst_n_i = 1'b0; mem_rdata_i = 32'd0; gap_pct = 0; cyc = 0;
    wr_pulses = 0; rd_pulses = 0; err_pulses = 0; overlap_cnt = 0;
    for (int i = 0; i < 8; i++) begin smem[i] = 32'd0; env_mem[i] = 32'd0; end
    for (int p = 0; p < 2; p++) begin issued[p] = 0; acked[p] = 0; end
    clear_ports();
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();                      // reset values

    // A writes 0xDEADBEEF to 8, then reads it back
    push_txn(0, 1'b1, 32'd8, 32'hDEADBEEF);
    push_txn(0, 1'b0, 32'd8, 32'h0);
    rst_n_i = 1'b1;
    update_ports();
    wr0 = wr_pulses;
    run_until_idle(40);
    check_val("t1_write_pulses", 32'(wr_pulses - wr0), 32'd1);
    check_val("t1_rdata", a_rdata_o, 32'hDEADBEEF);

    // A reads addr 30 and then addr 6: blocked only when the range check is built in
    push_txn(0, 1'b0, 32'd30, 32'h0);
    push_txn(0, 1'b0, 32'd6, 32'h0);
    rd0 = rd_pulses; err0 = err_pulses;
    update_ports();
    run_until_idle(40);
    check_val("rng_reads", 32'(rd_pulses - rd0), RANGE_EN ? 32'd0 : 32'd2);
    check_val("rng_errs", 32'(err_pulses - err0), RANGE_EN ? 32'd2 : 32'd0);
    check_val("rng_rdata", a_rdata_o, RANGE_EN ? 32'hDEADBEEF : env_mem[1]);

    // A and B read in the same cycle straight after reset: A first, then B
    reset_hold();
    push_txn(0, 1'b0, 32'd8, 32'h0);
    push_txn(1, 1'b0, 32'd4, 32'h0);
    update_ports();
    ack_log.delete();
    run_until_idle(40);
    check_val("dual_ack_cnt", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) check_val("dual_ack_gap", 32'(ack_log[1] - ack_log[0]), 32'd2);

    // Both ports keep requesting for 8 accesses: strict alternation, one ack every 2 cycles
    for (int i = 0; i < 4; i++) begin
      push_txn(0, 1'(i % 2), 32'(4 * i), $urandom());
      push_txn(1, 1'((i + 1) % 2), 32'(4 * i + 16), $urandom());
    end
    update_ports();
    ack_log.delete();
    run_until_idle(60);
    check_val("b2b_ack_cnt", 32'(ack_log.size()), 32'd8);
    if (ack_log.size() == 8) check_val("b2b_span", 32'(ack_log[7] - ack_log[0]), 32'd14);

    // Reset during the ACCESS cycle of a B read
    push_txn(1, 1'b0, 32'd12, 32'h0);
    update_ports();
    run_cycles(1);
    check_val("rst_setup_bgnt", 32'(b_gnt_o), 32'd1);
    rst_n_i = 1'b0;
    #1;
    check_val("rst_async", {a_gnt_o, b_gnt_o, a_ack_o, b_ack_o, err_o, mem_write_o, mem_read_o},
              32'd0);
    check_val("rst_mem_addr", mem_addr_o, 32'd0);
    check_val("rst_rdata", a_rdata_o | b_rdata_o, 32'd0);
    @(negedge clk);
    reset_hold();
    push_txn(0, 1'b1, 32'd16, 32'h12345678);
    update_ports();
    run_until_idle(40);
    check_val("post_rst_write", env_mem[4], 32'h12345678);

    // Random traffic, including some misaligned and out-of-range addresses
    gap_pct = 40;
    for (int i = 0; i < 60; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [31:0] ad;
        if ($urandom_range(9) == 0) ad = 32'($urandom_range(63));
        else ad = 32'($urandom_range(7)) * 32'd4;
        push_txn(p, 1'($urandom_range(1)), ad, $urandom());
      end
    end
    update_ports();
    run_until_idle(3000);

    check_val("a_all_acked", 32'(acked[0]), 32'(issued[0]));
    check_val("b_all_acked", 32'(acked[1]), 32'(issued[1]));
    check_val("gnt_overlap", 32'(overlap_cnt), 32'd0);
    for (int i = 0; i < 8; i++) check_val("mem_image", env_mem[i], smem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the byte-addressed data memory. It shares one memory between port A (CPU MEM stage) and port B (debug/loader port) using round-robin arbitration. It registers the winning request and drives the memory strobes for exactly one cycle. Read data is captured into a register and each access is acknowledged to its requester. It sits between the MEM-stage/loader logic and the data memory, whose interface is addr/data-in/MemWrite/MemRead/data-out with little-endian byte lanes.

## Interface
- MEM_BYTES, default 32: memory size in bytes; bound used by the range check.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- a_req_i  in  1  port A request; held until a_ack_o.
- a_we_i  in  1  port A write (1) / read (0); held with a_req_i.
- a_addr_i  in  32  port A byte address; held with a_req_i.
- a_wdata_i  in  32  port A write data; held with a_req_i.
- a_gnt_o  out  1  port A's access is in the ACCESS cycle.
- a_ack_o  out  1  one-cycle completion pulse for port A.
- a_rdata_o  out  32  port A read data; valid while a_ack_o=1 for a read.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_gnt_o, b_ack_o, b_rdata_o: port B, identical semantics.
- err_o  out  1  with ack: access was blocked by the range check.
- mem_addr_o  out  32  memory address.
- mem_wdata_o  out  32  memory write data.
- mem_write_o  out  1  memory write strobe.
- mem_read_o  out  1  memory read strobe.
- mem_rdata_i  in  32  memory read data.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Arbitration runs in IDLE and RESP.
  - Only one request present (excluding the port currently in RESP): that port wins.
  - Both requesting: the port selected by the priority pointer `rr` wins.
  - On every grant, `rr` is set to the other port.
  - `rr` resets to A.
- Grant: the winner's we/addr/wdata and a port-ID bit are latched, and the FSM enters ACCESS.
- ACCESS, one cycle:
  - mem_addr_o and mem_wdata_o come from the latch.
  - mem_write_o = we; mem_read_o = !we. Exactly one strobe is high.
  - The granted port's gnt_o is high.
  - At the end of the cycle, mem_rdata_i is captured into the rdata register and the FSM enters RESP.
- RESP, one cycle:
  - The granted port's ack_o = 1.
  - Both rdata_o outputs show the rdata register. Only the acked port may consume it.
  - Next state is ACCESS if any eligible request exists, otherwise IDLE.
  - The acked port's req_i is ignored in this cycle, because the requester drops it on the following edge.
- Outside ACCESS, all mem_* outputs are 0.
- Writes never update the rdata register.

## Timing
- Reset values: all gnt/ack outputs = 0, err_o = 0, rdata register = 0, mem_* = 0, state = IDLE, rr = A.
- Latency: request seen at edge N in IDLE → ACCESS during cycle N+1 → ack during cycle N+2.
- Throughput: one access per 2 cycles under back-to-back load.
- Both ports requesting continuously alternate as A, B, A, B… when starting from reset.
- Port requirement: req/we/addr/wdata must stay stable from assertion through the ack cycle. Dropping req before ack is illegal; the latched access still completes.
- Reset asserted mid-access: outputs clear immediately, asynchronously, and the FSM goes to IDLE. A write whose ACCESS cycle had begun may already be in memory. The requester reissues after reset.
- Reset release: the first grant is possible at the first edge after deassertion.

## Configuration
- DMEM_ARB_RANGE_CHK_EN defined:
  - At grant, an access with addr[1:0] != 0 or addr > MEM_BYTES-4 is flagged.
  - A flagged access still takes the ACCESS cycle, but both mem strobes stay 0.
  - In RESP, ack is issued with err_o = 1 and the rdata register is unchanged.
- DMEM_ARB_RANGE_CHK_EN undefined: no check is made, every access reaches memory, and err_o is tied to 0.

## Test plan
- Reset, then A writes 0xDEADBEEF to addr 8.
  - mem_write_o = 1 for one cycle, with mem_addr_o = 8.
  - a_ack_o is pulsed 2 cycles after req is sampled.
  - A then reads addr 8 → a_rdata_o = 0xDEADBEEF at ack.
- A and B both request reads in the same cycle after reset: A is granted first, then B. The acks are 2 cycles apart and b_gnt_o never overlaps a_gnt_o.
- Both ports hold requests for 8 accesses: grants strictly alternate A, B, A, B…, one ack every 2 cycles, with no idle cycle between accesses.
- Assert rst_n_i low during an ACCESS cycle of a B read: all outputs are 0 immediately, no ack is issued, and after release a new A request is served normally.
- With DMEM_ARB_RANGE_CHK_EN, A reads addr 30, then addr 6:
  - Each is acked with err_o = 1.
  - mem_read_o stays 0 throughout.
  - a_rdata_o keeps its previous value.
- Without the macro, the same stimulus gives err_o = 0 and mem_read_o = 1 for each access.
